// File: rtl/seq_mult_16bit.sv
// Iterative shift-add multiplier: one WIDTH-bit add per BUSY cycle, full product
// plus a saturated WIDTH-bit result and overflow flag, valid/ready on both sides.
module seq_mult_16bit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   sat,
  output logic               ovfl
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     mcand_r, acc_hi_r, acc_lo_r;
  logic [CW-1:0]        count_r;
  logic                 neg_r, signed_r;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   product_r;
  logic [WIDTH-1:0]     sat_r;
  logic                 ovfl_r, out_valid_r, in_ready_r;
  logic [WIDTH:0]       sat_res_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    logic [WIDTH-1:0] m;
    if (sgn && x[WIDTH-1]) m = ~x + WIDTH'(1);
    else                   m = x;
    return m;
  endfunction

  // Returns {ovfl, sat}; signed fit means the top WIDTH+1 bits are all equal.
  function automatic logic [WIDTH:0] saturate(input logic [2*WIDTH-1:0] p, input logic sgn);
    logic [WIDTH:0] r;
    if (sgn) begin
      if ((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1])) r = {1'b0, p[WIDTH-1:0]};
      else if (p[2*WIDTH-1])                                  r = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else                                                    r = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      if (|p[2*WIDTH-1:WIDTH]) r = {1'b1, {WIDTH{1'b1}}};
      else                     r = {1'b0, p[WIDTH-1:0]};
    end
    return r;
  endfunction

  // Partial-product adder and saturation of the registered product
  always_comb begin
    sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    sat_res_s = saturate(product_r, signed_r);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) state_s = BUSY;
        else                        state_s = IDLE;
      end
      BUSY: begin
        if (count_r == CW'(WIDTH-1)) state_s = FIX;
        else                         state_s = BUSY;
      end
      FIX:  state_s = DONE;
      DONE: begin
        if (out_valid_r && out_ready) state_s = IDLE;
        else                          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath and registered outputs; sat/ovfl come from the registered product,
  // so out_valid rises on the first DONE cycle edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r     <= {WIDTH{1'b0}};
      acc_hi_r    <= {WIDTH{1'b0}};
      acc_lo_r    <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      neg_r       <= 1'b0;
      signed_r    <= 1'b0;
      product_r   <= {(2*WIDTH){1'b0}};
      sat_r       <= {WIDTH{1'b0}};
      ovfl_r      <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      in_ready_r <= (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            mcand_r  <= magnitude(a, in_signed);
            acc_lo_r <= magnitude(b, in_signed);
            acc_hi_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            neg_r    <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            signed_r <= in_signed;
          end
        end
        BUSY: begin
          acc_hi_r <= sum_s[WIDTH:1];
          acc_lo_r <= {sum_s[0], acc_lo_r[WIDTH-1:1]};
          count_r  <= count_r + CW'(1);
        end
        FIX: begin
          if (neg_r) product_r <= ~{acc_hi_r, acc_lo_r} + (2*WIDTH)'(1);
          else       product_r <= {acc_hi_r, acc_lo_r};
        end
        DONE: begin
          if (!out_valid_r) begin
            sat_r       <= sat_res_s[WIDTH-1:0];
            ovfl_r      <= sat_res_s[WIDTH];
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign sat       = sat_r;
  assign ovfl      = ovfl_r;

endmodule

// File: tb/tb_seq_mult_16bit.sv
// Directed self-checking bench for seq_mult_16bit: results, latency,
// backpressure and mid-operation reset.
module tb_seq_mult_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [15:0] sat;
  logic        ovfl;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_mult_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .sat(sat), .ovfl(ovfl)
  );

  // Called #1 after an edge; returns #1 after the accept edge with scrambled inputs.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    else passes++;
    in_valid = 1'b1; a = av; b = bv; in_signed = sv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; in_signed = ~sv;
  endtask

  task automatic finish_op(input string name, input logic [31:0] ep, input logic [15:0] es,
                           input logic eo, input bit handshake);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 18) $display("FAIL %s_latency: got %0d cycles required 18", name, lat);
    else passes++;
    checks++;
    if (product !== ep) $display("FAIL %s_product: got %h required %h", name, product, ep);
    else passes++;
    checks++;
    if (sat !== es || ovfl !== eo)
      $display("FAIL %s_sat: got sat=%h ovfl=%b required sat=%h ovfl=%b", name, sat, ovfl, es, eo);
    else passes++;
    if (handshake) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL %s_release: got out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; in_signed = 1'b0; out_ready = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0 || sat !== 16'h0 || ovfl !== 1'b0)
      $display("FAIL reset_values: got rdy=%b vld=%b p=%h sat=%h ovfl=%b required 1 0 0 0 0",
               in_ready, out_valid, product, sat, ovfl);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    start_op(16'd3, 16'd5, 1'b0);
    finish_op("u_3x5", 32'h0000000F, 16'h000F, 1'b0, 1'b1);
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    finish_op("u_max", 32'hFFFE0001, 16'hFFFF, 1'b1, 1'b1);
  endtask

  task automatic test_signed();
    start_op(16'hFFFE, 16'h0003, 1'b1);
    finish_op("s_m2x3", 32'hFFFFFFFA, 16'hFFFA, 1'b0, 1'b1);
    start_op(16'h8000, 16'h8000, 1'b1);
    finish_op("s_minxmin", 32'h40000000, 16'h7FFF, 1'b1, 1'b1);
    start_op(16'h8000, 16'h0002, 1'b1);
    finish_op("s_minx2", 32'hFFFF0000, 16'h8000, 1'b1, 1'b1);
    start_op(16'h0000, 16'h8000, 1'b1);
    finish_op("s_zero", 32'h00000000, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_op(16'h0100, 16'h0200, 1'b0);
    finish_op("bp_first", 32'h00020000, 16'hFFFF, 1'b1, 1'b0);
    in_valid = 1'b1; a = 16'h1234; b = 16'h0002; in_signed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'h00020000 ||
          sat !== 16'hFFFF || ovfl !== 1'b1)
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b p=%h sat=%h ovfl=%b required 1 0 00020000 ffff 1",
                 i, out_valid, in_ready, product, sat, ovfl);
      else passes++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_accept: got in_ready=%b required 0", in_ready);
    else passes++;
    finish_op("bp_second", 32'h00002468, 16'h2468, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    start_op(16'h1111, 16'h2222, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0)
      $display("FAIL mid_reset: got rdy=%b vld=%b p=%h required 1 0 0", in_ready, out_valid, product);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) $display("FAIL mid_spurious: got %0d valid cycles required 0", spurious);
    else passes++;
    start_op(16'd7, 16'd9, 1'b0);
    finish_op("mid_after", 32'h0000003F, 16'h003F, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
